expr_sched: RTL and testbench
=============================

EXPR_SCHED -- requirements
Module: expr_sched

Interface
REQ-001 Parameter MAX_LEN, 16, maximum non-'=' characters per expression (evaluator buffer depth).
REQ-002 Parameter TIMEOUT, 64, cycles allowed from last streamed character to eval_valid.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  2  per-requester character-valid (bit i = requester i).
REQ-006 in_data0 / in_data1  in  8 each  ASCII character from requester 0 / 1; 61 ('=') terminates an expression.
REQ-007 in_ready  out  2  per-requester accept; a transfer occurs when in_valid[i] and in_ready[i] are both high.
REQ-008 eval_ascii  out  8  character to the shared evaluator.
REQ-009 eval_ready  out  1  one-cycle start pulse to the evaluator, coincident with the first character.
REQ-010 eval_valid  in  1  evaluator result strobe; eval_result  in  7  evaluator result.
REQ-011 out_valid  out  1; out_id  out  1  requester served; out_result  out  7; out_err  out  1; out_ready  in  1.

Function
REQ-012 Each requester SHALL own one expression buffer of MAX_LEN characters, with states LOAD, PEND and OVF.
REQ-013 In LOAD or OVF, in_ready[i]=1; otherwise 0.
REQ-014 In LOAD, an accepted non-'=' character SHALL be stored at the write index, which then increments.
REQ-015 An accepted character that would be number MAX_LEN+1 SHALL move the buffer to OVF; OVF discards characters until '='.
REQ-016 An accepted '=' SHALL move the buffer to PEND, and the terminator SHALL not be stored.
REQ-017 A PEND buffer is tagged error if it came from OVF or holds zero characters ("=" alone).
REQ-018 Scheduler FSM states: IDLE, STREAM, WAIT, GAP, OUT.
REQ-019 IDLE: when one buffer is PEND, grant it; when both are PEND, grant the requester not served last (round-robin; requester 0 wins the first tie after reset).
REQ-020 On grant, an error-tagged buffer SHALL go directly to OUT with out_err=1 and out_result=0, and the buffer SHALL be released to LOAD.
REQ-021 STREAM: drive one stored character per cycle in index order, with eval_ready=1 on the first cycle only.
REQ-022 After the last stored character, STREAM SHALL drive 61 for exactly one cycle, release the buffer to LOAD, then go to WAIT.
REQ-023 Outside STREAM, eval_ascii=0 and eval_ready=0; 61 SHALL never be driven outside STREAM.
REQ-024 WAIT: on eval_valid, capture eval_result and set out_err=0, then go to GAP.
REQ-025 WAIT: if TIMEOUT cycles elapse without eval_valid, set out_err=1 and out_result=0, then go to GAP.
REQ-026 GAP: one idle cycle (covers the evaluator's post-result recovery cycle), then go to OUT.
REQ-027 OUT: out_valid=1 with out_id, out_result and out_err held stable until out_ready; then go to IDLE. out_ready while out_valid=0 SHALL be ignored.
REQ-028 A released buffer SHALL accept a new expression concurrently with WAIT, GAP and OUT of the current job.
REQ-029 Latency for an expression of N characters (no error) SHALL be N+1 cycles of STREAM plus the evaluator latency, plus 1 cycle of GAP, before out_valid.
REQ-030 eval_valid outside WAIT SHALL be ignored.

Reset
REQ-031 While rst_n=0: FSM=IDLE, buffers in LOAD and empty, round-robin pointer set to requester 1 (so requester 0 wins next), timeout counter cleared.
REQ-032 Reset values: in_ready=2'b11, eval_ascii=0, eval_ready=0, out_valid=0, out_id=0, out_result=0, out_err=0.
REQ-033 Reset asserted mid-operation SHALL abort the job with no output.

Structure
REQ-034 Shared package aec_pkg SHALL hold ASCII_EQ=61, MAX_LEN, TIMEOUT and the scheduler state enum.
REQ-035 The per-requester buffer SHALL be sub-module expr_buf, instantiated twice; arbitration and the FSM live in expr_sched.

Verification
REQ-036 Req0 sends "3+4=" with a model evaluator -> eval_ready pulses with '3', then '+', '4', '=' on consecutive cycles; out_valid, out_id=0, out_result=7, out_err=0.
REQ-037 Both requesters hold PEND simultaneously after reset -> requester 0 served, then requester 1; the next tie serves requester 0.
REQ-038 Req1 sends 17 digits then "=" -> evaluator untouched; out_id=1, out_err=1, out_result=0.
REQ-039 Req0 sends "=" -> out_err=1 with no eval_ready pulse.
REQ-040 Evaluator never asserts eval_valid -> out_err=1 exactly TIMEOUT cycles after the '=' cycle, plus GAP.
REQ-041 out_ready held low for 5 cycles, with rst_n pulsed low during STREAM in a second run -> outputs stable while stalled; reset returns all outputs to zero and in_ready=2'b11.

Source files
------------

// File: rtl/aec_pkg.sv
// rtl/aec_pkg.sv - shared constants and state types for the expression scheduler
package aec_pkg;

  localparam logic [7:0] ASCII_EQ = 8'd61;
  localparam int         MAX_LEN  = 16;
  localparam int         TIMEOUT  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_GAP,
    S_OUT
  } sched_state_t;

  typedef enum logic [1:0] {
    B_LOAD,
    B_PEND,
    B_OVF
  } buf_state_t;

endpackage

// File: rtl/expr_buf.sv
// rtl/expr_buf.sv - per-requester expression buffer (LOAD / PEND / OVF)
module expr_buf #(
  parameter int LEN = aec_pkg::MAX_LEN,
  localparam int IW = $clog2(LEN),
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          rel,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic          pend,
  output logic          err,
  output logic [CW-1:0] len
);
  import aec_pkg::*;

  buf_state_t    st;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [LEN];
  logic          acc;
  logic          is_eq;
  logic          full;

  assign in_ready = (st != B_PEND);
  assign acc      = in_valid && in_ready;
  assign is_eq    = (in_data == ASCII_EQ);
  assign full     = (cnt == CW'(LEN));
  assign pend     = (st == B_PEND);
  assign len      = cnt;
  assign rd_data  = mem[rd_idx];

  // Buffer state, write index and error tag; release from the scheduler empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= B_LOAD;
      cnt <= '0;
      err <= 1'b0;
    end else if (rel) begin
      st  <= B_LOAD;
      cnt <= '0;
      err <= 1'b0;
    end else if (acc) begin
      case (st)
        B_LOAD: begin
          if (is_eq) begin
            st  <= B_PEND;
            err <= (cnt == '0);
          end else if (full) begin
            st <= B_OVF;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_OVF: begin
          if (is_eq) begin
            st  <= B_PEND;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Character storage; the terminator and overflow characters are never written.
  always_ff @(posedge clk) begin
    if (acc && st == B_LOAD && !is_eq && !full) begin
      mem[cnt[IW-1:0]] <= in_data;
    end
  end

endmodule

// File: rtl/expr_sched.sv
// rtl/expr_sched.sv - two-requester expression scheduler in front of a shared evaluator
module expr_sched #(
  parameter int MAX_LEN = aec_pkg::MAX_LEN,
  parameter int TIMEOUT = aec_pkg::TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in_valid,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  output logic [1:0] in_ready,
  output logic [7:0] eval_ascii,
  output logic       eval_ready,
  input  logic       eval_valid,
  input  logic [6:0] eval_result,
  output logic       out_valid,
  output logic       out_id,
  output logic [6:0] out_result,
  output logic       out_err,
  input  logic       out_ready
);
  import aec_pkg::*;

  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t  state;
  sched_state_t  state_nx;
  logic [1:0]    pend;
  logic [1:0]    err;
  logic [1:0]    rel;
  logic [CW-1:0] len [2];
  logic [7:0]    rd_data [2];
  logic [CW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic          cur;
  logic          rr_last;
  logic          grant_any;
  logic          grant_id;
  logic          tmo;

  expr_buf #(.LEN(MAX_LEN)) u_buf0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[0]),
    .in_data  (in_data0),
    .in_ready (in_ready[0]),
    .rel      (rel[0]),
    .rd_idx   (idx[IW-1:0]),
    .rd_data  (rd_data[0]),
    .pend     (pend[0]),
    .err      (err[0]),
    .len      (len[0])
  );

  expr_buf #(.LEN(MAX_LEN)) u_buf1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[1]),
    .in_data  (in_data1),
    .in_ready (in_ready[1]),
    .rel      (rel[1]),
    .rd_idx   (idx[IW-1:0]),
    .rd_data  (rd_data[1]),
    .pend     (pend[1]),
    .err      (err[1]),
    .len      (len[1])
  );

  assign tmo = (tcnt == TW'(TIMEOUT - 1));

  // Round-robin arbitration: on a tie the requester not served last wins.
  always_comb begin
    grant_any = |pend;
    grant_id  = 1'b0;
    if (pend == 2'b11) begin
      grant_id = ~rr_last;
    end else begin
      grant_id = pend[1];
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, evaluator stream and buffer release decode.
  always_comb begin
    state_nx   = state;
    rel        = 2'b00;
    eval_ascii = 8'd0;
    eval_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          if (err[grant_id]) begin
            rel[grant_id] = 1'b1;
            state_nx      = S_OUT;
          end else begin
            state_nx = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        eval_ready = (idx == '0);
        if (idx == len[cur]) begin
          eval_ascii = ASCII_EQ;
          rel[cur]   = 1'b1;
          state_nx   = S_WAIT;
        end else begin
          eval_ascii = rd_data[cur];
        end
      end
      S_WAIT: begin
        if (eval_valid || tmo) begin
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        state_nx = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job datapath: grant bookkeeping, stream index, timeout counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= 1'b0;
      rr_last    <= 1'b1;
      idx        <= '0;
      tcnt       <= '0;
      out_id     <= 1'b0;
      out_result <= 7'd0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            cur     <= grant_id;
            rr_last <= grant_id;
            out_id  <= grant_id;
            idx     <= '0;
            if (err[grant_id]) begin
              out_err    <= 1'b1;
              out_result <= 7'd0;
            end
          end
        end
        S_STREAM: begin
          idx  <= idx + CW'(1);
          tcnt <= '0;
        end
        S_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (eval_valid) begin
            out_result <= eval_result;
            out_err    <= 1'b0;
          end else if (tmo) begin
            out_result <= 7'd0;
            out_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_sched.sv
// tb/tb_expr_sched.sv - directed self-checking bench for expr_sched
module tb_expr_sched;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic [1:0] in_ready;
  logic [7:0] eval_ascii;
  logic       eval_ready;
  logic       eval_valid;
  logic [6:0] eval_result;
  logic       out_valid;
  logic       out_id;
  logic [6:0] out_result;
  logic       out_err;
  logic       out_ready;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  // evaluator model state
  bit  eval_en;
  bit  ev_act;
  bit  ev_due;
  int  ev_acc;
  int  ev_cur;
  byte ev_op;
  int  ev_starts = 0;

  expr_sched #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data0    (in_data0),
    .in_data1    (in_data1),
    .in_ready    (in_ready),
    .eval_ascii  (eval_ascii),
    .eval_ready  (eval_ready),
    .eval_valid  (eval_valid),
    .eval_result (eval_result),
    .out_valid   (out_valid),
    .out_id      (out_id),
    .out_result  (out_result),
    .out_err     (out_err),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Evaluator: left-to-right +/- over decimal numbers, result one cycle after '='.
  always @(negedge clk) begin
    eval_valid = 1'b0;
    if (!rst_n) begin
      ev_act = 1'b0;
      ev_due = 1'b0;
    end else begin
      if (ev_due) begin
        eval_valid  = eval_en;
        eval_result = ev_acc[6:0];
        ev_due      = 1'b0;
      end
      if (eval_ready) begin
        ev_starts++;
        ev_act = 1'b1;
        ev_acc = 0;
        ev_cur = 0;
        ev_op  = "+";
      end
      if (ev_act) begin
        if (eval_ascii >= 8'd48 && eval_ascii <= 8'd57) begin
          ev_cur = ev_cur * 10 + int'(eval_ascii) - 48;
        end else begin
          ev_acc = (ev_op == "-") ? ev_acc - ev_cur : ev_acc + ev_cur;
          ev_cur = 0;
          if (eval_ascii == 8'd61) begin
            ev_act = 1'b0;
            ev_due = 1'b1;
          end else begin
            ev_op = byte'(eval_ascii);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input string s);
    for (int k = 0; k < s.len(); k++) begin
      in_valid[r] = 1'b1;
      if (r == 0) in_data0 = s[k];
      else        in_data1 = s[k];
      tick();
    end
    in_valid[r] = 1'b0;
  endtask

  task automatic send2(input string s0, input string s1);
    for (int k = 0; k < s0.len(); k++) begin
      in_valid = 2'b11;
      in_data0 = s0[k];
      in_data1 = s1[k];
      tick();
    end
    in_valid = 2'b00;
  endtask

  task automatic wait_start(input string tag);
    for (int k = 0; k < 40 && !eval_ready; k++) tick();
    chk(tag, eval_ready, 1);
  endtask

  task automatic wait_out(input string tag);
    for (int k = 0; k < 300 && !out_valid; k++) tick();
    chk(tag, out_valid, 1);
  endtask

  task automatic take_out(input string tag, input int id, input int res, input int er);
    wait_out({tag, "_valid"});
    chk({tag, "_id"}, out_id, id);
    chk({tag, "_result"}, out_result, res);
    chk({tag, "_err"}, out_err, er);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int cs;
    int s0;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    in_data0  = 8'd0;
    in_data1  = 8'd0;
    out_ready = 1'b0;
    eval_en   = 1'b1;
    eval_valid  = 1'b0;
    eval_result = 7'd0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_eval_ascii", eval_ascii, 0);
    chk("rst_eval_ready", eval_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    tick();

    // "3+4=" from requester 0: stream order, latency, result
    send(0, "3+4=");
    chk("pend_in_ready", in_ready, 2'b10);
    wait_start("t1_start");
    cs = cyc;
    chk("t1_c0", eval_ascii, "3");
    tick();
    chk("t1_c1", {eval_ready, eval_ascii}, {1'b0, 8'd43});
    tick();
    chk("t1_c2", {eval_ready, eval_ascii}, {1'b0, 8'd52});
    tick();
    chk("t1_c3", {eval_ready, eval_ascii}, {1'b0, 8'd61});
    tick();
    chk("t1_after_eq", eval_ascii, 0);
    wait_out("t1_wait");
    chk("t1_latency", cyc - cs, 6);
    take_out("t1", 0, 7, 0);

    // ties after reset: 0 then 1, and the next tie again 0 then 1
    do_reset();
    send2("1+2=", "5-3=");
    take_out("tie1a", 0, 3, 0);
    take_out("tie1b", 1, 2, 0);
    send2("2+2=", "9-1=");
    take_out("tie2a", 0, 4, 0);
    take_out("tie2b", 1, 8, 0);

    // lone "=" is an error without touching the evaluator
    s0 = ev_starts;
    send(0, "=");
    take_out("empty", 0, 0, 1);
    chk("empty_no_start", ev_starts, s0);

    // requester 0 served last, so a tie now goes to requester 1
    send2("6+1=", "2+3=");
    take_out("tie3a", 1, 5, 0);
    take_out("tie3b", 0, 7, 0);

    // 17 characters overflow the buffer
    s0 = ev_starts;
    send(1, "12345678901234567=");
    take_out("ovf", 1, 0, 1);
    chk("ovf_no_start", ev_starts, s0);

    // exactly MAX_LEN characters still evaluate
    send(0, "1+1+1+1+1+1+1+12=");
    take_out("full", 0, 19, 0);

    // evaluator silent: timeout error TIMEOUT cycles after '=' plus the gap
    eval_en = 1'b0;
    send(0, "8=");
    for (int k = 0; k < 40 && eval_ascii != 8'd61; k++) tick();
    chk("tmo_eq_seen", eval_ascii, 61);
    cs = cyc;
    wait_out("tmo_wait");
    chk("tmo_latency", cyc - cs, TIMEOUT + 2);
    take_out("tmo", 0, 0, 1);
    eval_en = 1'b1;

    // output stall: held stable for 5 cycles
    send(0, "2+5=");
    wait_out("stall_wait");
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold", {out_valid, out_id, out_err, out_result}, {1'b1, 1'b0, 1'b0, 7'd7});
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_released", out_valid, 0);

    // reset during STREAM aborts the job
    send(1, "1+1=");
    wait_start("rst_start");
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", in_ready, 2'b11);
    chk("mid_eval", {eval_ready, eval_ascii}, 0);
    chk("mid_out", {out_valid, out_id, out_err, out_result}, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid || eval_ready) seen++;
      tick();
    end
    chk("abort_quiet", seen, 0);
    send(0, "4+4=");
    take_out("post_rst", 0, 8, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
